// File: rtl/ffsr_pulse_bank.sv
// ---------------------------------------------------------------------------
// ffsr_pulse_bank
//
// Purpose:
//   A bank of CHANNELS independent level registers. Each level lies in
//   0..INPUT_SIZE and is moved by increment/decrement strobes or replaced by
//   a binary parallel load. Each level is presented either as a one-hot pulse
//   code or as a thermometer code, selected at run time. An optional shared
//   leak timer removes one unit from every non-loading channel once every
//   LEAK_PERIOD enabled cycles, modelling membrane decay in the spiking
//   front end.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   en         global enable; when low all state holds, leak timer included
//   mode       0 = pulse (one-hot), 1 = thermometer; registered before use
//   load       per-channel parallel-load strobe
//   init       per-channel binary load value, channel c at [c*LW +: LW]
//   inc        per-channel increment strobe
//   dec        per-channel decrement strobe
//   out        encoded code, channel c at [c*INPUT_SIZE +: INPUT_SIZE]
//   level      registered binary level, channel c at [c*LW +: LW]
//   full       level == INPUT_SIZE
//   empty      level == 0
//   leak_tick  high during the cycle in which a leak is applied
// ---------------------------------------------------------------------------
module ffsr_pulse_bank #(
    parameter int INPUT_SIZE  = 16,
    parameter int CHANNELS    = 4,
    parameter int LEAK_PERIOD = 0,
    parameter int LW          = $clog2(INPUT_SIZE + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           mode,
    input  logic [CHANNELS-1:0]            load,
    input  logic [CHANNELS*LW-1:0]         init,
    input  logic [CHANNELS-1:0]            inc,
    input  logic [CHANNELS-1:0]            dec,
    output logic [CHANNELS*INPUT_SIZE-1:0] out,
    output logic [CHANNELS*LW-1:0]         level,
    output logic [CHANNELS-1:0]            full,
    output logic [CHANNELS-1:0]            empty,
    output logic                           leak_tick
);

    // Signed working width: two guard bits so that level+1 and level-2 can
    // be represented without wrapping before the clamp is applied.
    localparam int SW = LW + 2;

    localparam logic        [LW-1:0] MAX_LVL = LW'(INPUT_SIZE);
    localparam logic signed [SW-1:0] MAX_S   = SW'(INPUT_SIZE);
    localparam logic signed [SW-1:0] ZERO_S  = '0;
    localparam logic signed [SW-1:0] ONE_S   = SW'(1);

    logic [LW-1:0]        level_q [CHANNELS];
    logic [LW-1:0]        level_d [CHANNELS];
    logic [LW-1:0]        init_c  [CHANNELS];
    logic signed [SW-1:0] sum     [CHANNELS];
    logic                 mode_q;
    logic                 mode_d;

    // Shared leak timer. When LEAK_PERIOD is 0 no counter exists at all and
    // the tick is tied low. The tick is gated by rst so that it reads 0
    // while reset is held even for a period of 1.
    generate
        if (LEAK_PERIOD > 0) begin : g_leak
            localparam int CW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
            localparam logic [CW-1:0] LAST = CW'(LEAK_PERIOD - 1);

            logic [CW-1:0] leak_cnt_q;
            logic [CW-1:0] leak_cnt_d;

            // Count enabled cycles 0..LEAK_PERIOD-1 and wrap; hold when
            // the bank is disabled.
            always_comb begin
                leak_cnt_d = leak_cnt_q;
                if (en) begin
                    if (leak_cnt_q == LAST) begin
                        leak_cnt_d = '0;
                    end else begin
                        leak_cnt_d = leak_cnt_q + 1'b1;
                    end
                end
            end

            // Leak counter register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    leak_cnt_q <= '0;
                end else begin
                    leak_cnt_q <= leak_cnt_d;
                end
            end

            assign leak_tick = rst & en & (leak_cnt_q == LAST);
        end else begin : g_no_leak
            assign leak_tick = 1'b0;
        end
    endgenerate

    // Mode is resampled on every enabled edge, so a change on the mode pin
    // reaches the encoder one cycle later.
    always_comb begin
        mode_d = mode_q;
        if (en) begin
            mode_d = mode;
        end
    end

    // Next-level computation per channel. A load wins outright and
    // saturates out-of-range values to INPUT_SIZE. Otherwise the net delta
    // of inc, dec and the shared leak is added in signed arithmetic and
    // clamped to 0..INPUT_SIZE, so opposing strobes cancel and nothing
    // wraps at either end.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            init_c[c]  = init[c*LW +: LW];
            sum[c]     = $signed({2'b00, level_q[c]});
            level_d[c] = level_q[c];

            if (en) begin
                if (load[c]) begin
                    if (init_c[c] > MAX_LVL) begin
                        level_d[c] = MAX_LVL;
                    end else begin
                        level_d[c] = init_c[c];
                    end
                end else begin
                    if (inc[c]) begin
                        sum[c] = sum[c] + ONE_S;
                    end
                    if (dec[c]) begin
                        sum[c] = sum[c] - ONE_S;
                    end
                    if (leak_tick) begin
                        sum[c] = sum[c] - ONE_S;
                    end

                    if (sum[c] < ZERO_S) begin
                        level_d[c] = '0;
                    end else if (sum[c] > MAX_S) begin
                        level_d[c] = MAX_LVL;
                    end else begin
                        level_d[c] = sum[c][LW-1:0];
                    end
                end
            end
        end
    end

    // Level and mode registers; reset discards everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                level_q[c] <= '0;
            end
        end else begin
            mode_q <= mode_d;
            for (int c = 0; c < CHANNELS; c++) begin
                level_q[c] <= level_d[c];
            end
        end
    end

    // Output decode, purely from registered state. Bit b of a slice stands
    // for level b+1: pulse mode lights only the bit for the current level,
    // thermometer mode lights every bit at or below it. Level 0 is all
    // zeros in both modes.
    always_comb begin
        out   = '0;
        level = '0;
        full  = '0;
        empty = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            level[c*LW +: LW] = level_q[c];
            full[c]           = (level_q[c] == MAX_LVL);
            empty[c]          = (level_q[c] == '0);
            for (int b = 0; b < INPUT_SIZE; b++) begin
                if (mode_q) begin
                    out[c*INPUT_SIZE + b] = (LW'(b) < level_q[c]);
                end else begin
                    out[c*INPUT_SIZE + b] = (level_q[c] == LW'(b + 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_ffsr_pulse_bank.sv
// ---------------------------------------------------------------------------
// tb_ffsr_pulse_bank
//
// Drives two copies of the bank from the same stimulus: one with the leak
// timer disabled and one with LEAK_PERIOD = 4. A small behavioural model
// (integer levels, a count of enabled cycles) predicts both.
// ---------------------------------------------------------------------------
module tb_ffsr_pulse_bank;

    localparam int IS = 16;
    localparam int CH = 4;
    localparam int LW = 5;
    localparam int LP = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic [CH-1:0]    load;
    logic [CH*LW-1:0] init;
    logic [CH-1:0]    inc;
    logic [CH-1:0]    dec;

    logic [CH*IS-1:0] out0;
    logic [CH*IS-1:0] outl;
    logic [CH*LW-1:0] level0;
    logic [CH*LW-1:0] levell;
    logic [CH-1:0]    full0;
    logic [CH-1:0]    fulll;
    logic [CH-1:0]    empty0;
    logic [CH-1:0]    emptyl;
    logic             tick0;
    logic             tickl;

    int checks   = 0;
    int failures = 0;

    // Reference model state: levels per DUT (0 = no leak, 1 = leak),
    // registered mode, and number of enabled cycles since reset.
    int m_lvl [2][CH];
    int m_mode;
    int en_cycles;

    ffsr_pulse_bank #(.INPUT_SIZE(IS), .CHANNELS(CH), .LEAK_PERIOD(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .init(init),
        .inc(inc), .dec(dec), .out(out0), .level(level0), .full(full0),
        .empty(empty0), .leak_tick(tick0)
    );

    ffsr_pulse_bank #(.INPUT_SIZE(IS), .CHANNELS(CH), .LEAK_PERIOD(LP)) dutl (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .init(init),
        .inc(inc), .dec(dec), .out(outl), .level(levell), .full(fulll),
        .empty(emptyl), .leak_tick(tickl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected code word for a level under a given mode, from plain arithmetic.
    function automatic logic [IS-1:0] enc(int lvl, int md);
        int t;
        if (md != 0) t = (1 << lvl) - 1;
        else if (lvl == 0) t = 0;
        else t = 1 << (lvl - 1);
        return t[IS-1:0];
    endfunction

    // Model: a leak happens on every LP-th enabled cycle.
    function automatic logic exp_tick();
        return (en === 1'b1) && ((en_cycles % LP) == LP - 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) m_lvl[d][c] = 0;
        m_mode    = 0;
        en_cycles = 0;
    endtask

    task automatic idle();
        en   = 1'b1;
        load = '0;
        inc  = '0;
        dec  = '0;
        init = '0;
    endtask

    // Advance one clock and update the model from the inputs held over it.
    task automatic cycle();
        int tk;
        int nv;
        tk = exp_tick() ? 1 : 0;
        @(posedge clk);
        if (rst === 1'b1 && en === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    if (load[c]) begin
                        nv = int'(init[c*LW +: LW]);
                        if (nv > IS) nv = IS;
                    end else begin
                        nv = m_lvl[d][c] + int'(inc[c]) - int'(dec[c]) - ((d == 1) ? tk : 0);
                        if (nv < 0) nv = 0;
                        if (nv > IS) nv = IS;
                    end
                    m_lvl[d][c] = nv;
                end
            end
            m_mode = int'(mode);
            en_cycles++;
        end
        #1;
    endtask

    task automatic apply_reset(int n);
        idle();
        mode = 1'b0;
        rst  = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        mode = 1'b1;
        inc  = 4'b1111;
        load = 4'b0101;
        init = '1;
        rst  = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks += 6;
            if (out0 !== '0) begin failures++; $display("[TB] FAIL reset_out0: got %0h expected 0", out0); end
            if (outl !== '0) begin failures++; $display("[TB] FAIL reset_outl: got %0h expected 0", outl); end
            if (empty0 !== 4'b1111) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 1111", empty0); end
            if (full0 !== 4'b0000) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0000", full0); end
            if (levell !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0h expected 0", levell); end
            if (tickl !== 1'b0) begin failures++; $display("[TB] FAIL reset_tick: got %b expected 0", tickl); end
        end
        @(negedge clk);
        rst = 1'b1;
        idle();
        mode = 1'b0;
        load = 4'b0001;
        init = '0;
        init[0 +: LW] = 5'd5;
        cycle();
        checks += 3;
        if (level0[0 +: LW] !== 5'd5) begin failures++; $display("[TB] FAIL load_level: got %0d expected 5", level0[0 +: LW]); end
        if (out0[0 +: IS] !== 16'h0010) begin failures++; $display("[TB] FAIL load_pulse: got %h expected 0010", out0[0 +: IS]); end
        if (levell[0 +: LW] !== m_lvl[1][0][LW-1:0]) begin failures++; $display("[TB] FAIL load_level_l: got %0d expected %0d", levell[0 +: LW], m_lvl[1][0]); end
        idle();
        mode = 1'b1;
        #1;
        checks++;
        if (out0[0 +: IS] !== 16'h0010) begin failures++; $display("[TB] FAIL mode_early: got %h expected 0010", out0[0 +: IS]); end
        cycle();
        checks++;
        if (out0[0 +: IS] !== 16'h001F) begin failures++; $display("[TB] FAIL mode_therm: got %h expected 001f", out0[0 +: IS]); end
    endtask

    task automatic test_saturation();
        idle();
        mode = 1'b1;
        inc  = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks += 3;
            if (level0[LW +: LW] !== m_lvl[0][1][LW-1:0]) begin failures++; $display("[TB] FAIL sat_inc_level k=%0d: got %0d expected %0d", k, level0[LW +: LW], m_lvl[0][1]); end
            if (full0[1] !== (k >= 15)) begin failures++; $display("[TB] FAIL sat_full k=%0d: got %b expected %b", k, full0[1], (k >= 15)); end
            if (levell[LW +: LW] !== m_lvl[1][1][LW-1:0]) begin failures++; $display("[TB] FAIL sat_inc_level_l k=%0d: got %0d expected %0d", k, levell[LW +: LW], m_lvl[1][1]); end
        end
        checks += 2;
        if (level0[LW +: LW] !== 5'd16) begin failures++; $display("[TB] FAIL sat_top: got %0d expected 16", level0[LW +: LW]); end
        if (out0[IS +: IS] !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_therm: got %h expected ffff", out0[IS +: IS]); end
        idle();
        dec = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks += 2;
            if (level0[LW +: LW] !== m_lvl[0][1][LW-1:0]) begin failures++; $display("[TB] FAIL sat_dec_level k=%0d: got %0d expected %0d", k, level0[LW +: LW], m_lvl[0][1]); end
            if (empty0[1] !== (k >= 15)) begin failures++; $display("[TB] FAIL sat_empty k=%0d: got %b expected %b", k, empty0[1], (k >= 15)); end
        end
        checks++;
        if (level0[LW +: LW] !== 5'd0) begin failures++; $display("[TB] FAIL sat_bottom: got %0d expected 0", level0[LW +: LW]); end
        idle();
        load = 4'b0010;
        init[LW +: LW] = 5'd25;
        cycle();
        checks += 2;
        if (level0[LW +: LW] !== 5'd16) begin failures++; $display("[TB] FAIL init_clamp: got %0d expected 16", level0[LW +: LW]); end
        if (levell[LW +: LW] !== 5'd16) begin failures++; $display("[TB] FAIL init_clamp_l: got %0d expected 16", levell[LW +: LW]); end
    endtask

    task automatic test_simultaneous();
        idle();
        load = 4'b0100;
        init[2*LW +: LW] = 5'd7;
        cycle();
        idle();
        inc  = 4'b1100;
        dec  = 4'b0100;
        load = 4'b1000;
        init[3*LW +: LW] = 5'd3;
        cycle();
        checks += 3;
        if (level0[2*LW +: LW] !== 5'd7) begin failures++; $display("[TB] FAIL incdec_hold: got %0d expected 7", level0[2*LW +: LW]); end
        if (level0[3*LW +: LW] !== 5'd3) begin failures++; $display("[TB] FAIL load_over_inc: got %0d expected 3", level0[3*LW +: LW]); end
        if (levell[3*LW +: LW] !== 5'd3) begin failures++; $display("[TB] FAIL load_over_inc_l: got %0d expected 3", levell[3*LW +: LW]); end
    endtask

    task automatic test_leak();
        int nticks;
        int guard;
        apply_reset(2);
        idle();
        load = 4'b0011;
        init[0 +: LW] = 5'd2;
        cycle();
        nticks = 0;
        idle();
        for (int k = 0; k < 10; k++) begin
            #1;
            checks += 2;
            if (tickl !== exp_tick()) begin failures++; $display("[TB] FAIL leak_tick k=%0d: got %b expected %b", k, tickl, exp_tick()); end
            if (tick0 !== 1'b0) begin failures++; $display("[TB] FAIL leak_tick_off k=%0d: got %b expected 0", k, tick0); end
            if (tickl === 1'b1) nticks++;
            cycle();
            checks += 2;
            if (levell[0 +: LW] !== m_lvl[1][0][LW-1:0]) begin failures++; $display("[TB] FAIL leak_ch0 k=%0d: got %0d expected %0d", k, levell[0 +: LW], m_lvl[1][0]); end
            if (levell[LW +: LW] !== m_lvl[1][1][LW-1:0]) begin failures++; $display("[TB] FAIL leak_ch1 k=%0d: got %0d expected %0d", k, levell[LW +: LW], m_lvl[1][1]); end
        end
        checks += 3;
        if (nticks !== 2) begin failures++; $display("[TB] FAIL leak_count: got %0d expected 2", nticks); end
        if (levell[0 +: LW] !== 5'd0) begin failures++; $display("[TB] FAIL leak_ch0_final: got %0d expected 0", levell[0 +: LW]); end
        if (level0[0 +: LW] !== 5'd2) begin failures++; $display("[TB] FAIL noleak_ch0: got %0d expected 2", level0[0 +: LW]); end
        idle();
        load = 4'b1100;
        init[2*LW +: LW] = 5'd5;
        init[3*LW +: LW] = 5'd5;
        cycle();
        idle();
        guard = 0;
        while ((en_cycles % LP) != LP - 1 && guard < 8) begin
            cycle();
            guard++;
        end
        inc = 4'b0100;
        dec = 4'b1000;
        #1;
        checks++;
        if (tickl !== 1'b1) begin failures++; $display("[TB] FAIL leak_coincide_tick: got %b expected 1", tickl); end
        cycle();
        checks += 2;
        if (levell[2*LW +: LW] !== 5'd5) begin failures++; $display("[TB] FAIL leak_inc_hold: got %0d expected 5", levell[2*LW +: LW]); end
        if (levell[3*LW +: LW] !== 5'd3) begin failures++; $display("[TB] FAIL leak_dec_two: got %0d expected 3", levell[3*LW +: LW]); end
    endtask

    task automatic test_enable();
        idle();
        mode = 1'b1;
        load = 4'b1111;
        for (int c = 0; c < CH; c++) init[c*LW +: LW] = LW'($urandom_range(1, IS));
        cycle();
        for (int k = 0; k < 10; k++) begin
            en   = 1'b0;
            mode = 1'b0;
            load = CH'($urandom);
            inc  = CH'($urandom);
            dec  = CH'($urandom);
            init = (CH*LW)'($urandom);
            #1;
            checks++;
            if (tickl !== 1'b0) begin failures++; $display("[TB] FAIL en_tick k=%0d: got %b expected 0", k, tickl); end
            cycle();
            for (int c = 0; c < CH; c++) begin
                checks += 2;
                if (levell[c*LW +: LW] !== m_lvl[1][c][LW-1:0]) begin failures++; $display("[TB] FAIL en_hold k=%0d ch%0d: got %0d expected %0d", k, c, levell[c*LW +: LW], m_lvl[1][c]); end
                if (out0[c*IS +: IS] !== enc(m_lvl[0][c], m_mode)) begin failures++; $display("[TB] FAIL en_mode k=%0d ch%0d: got %h expected %h", k, c, out0[c*IS +: IS], enc(m_lvl[0][c], m_mode)); end
            end
        end
        idle();
        mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (tickl !== exp_tick()) begin failures++; $display("[TB] FAIL en_resume_tick k=%0d: got %b expected %b", k, tickl, exp_tick()); end
            cycle();
        end
    endtask

    task automatic test_random();
        logic [CH*IS-1:0] o;
        logic [CH*LW-1:0] l;
        logic [CH-1:0]    f;
        logic [CH-1:0]    e;
        for (int k = 0; k < 300; k++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            for (int c = 0; c < CH; c++) begin
                load[c] = ($urandom_range(0, 9) == 0);
                inc[c]  = $urandom_range(0, 1);
                dec[c]  = $urandom_range(0, 1);
                init[c*LW +: LW] = LW'($urandom_range(0, 31));
            end
            #1;
            checks += 2;
            if (tickl !== exp_tick()) begin failures++; $display("[TB] FAIL rnd_tick k=%0d: got %b expected %b", k, tickl, exp_tick()); end
            if (tick0 !== 1'b0) begin failures++; $display("[TB] FAIL rnd_tick0 k=%0d: got %b expected 0", k, tick0); end
            cycle();
            for (int d = 0; d < 2; d++) begin
                o = (d == 0) ? out0 : outl;
                l = (d == 0) ? level0 : levell;
                f = (d == 0) ? full0 : fulll;
                e = (d == 0) ? empty0 : emptyl;
                for (int c = 0; c < CH; c++) begin
                    checks += 4;
                    if (l[c*LW +: LW] !== m_lvl[d][c][LW-1:0]) begin failures++; $display("[TB] FAIL rnd_level k=%0d dut%0d ch%0d: got %0d expected %0d", k, d, c, l[c*LW +: LW], m_lvl[d][c]); end
                    if (o[c*IS +: IS] !== enc(m_lvl[d][c], m_mode)) begin failures++; $display("[TB] FAIL rnd_out k=%0d dut%0d ch%0d: got %h expected %h", k, d, c, o[c*IS +: IS], enc(m_lvl[d][c], m_mode)); end
                    if (f[c] !== (m_lvl[d][c] == IS)) begin failures++; $display("[TB] FAIL rnd_full k=%0d dut%0d ch%0d: got %b expected %b", k, d, c, f[c], (m_lvl[d][c] == IS)); end
                    if (e[c] !== (m_lvl[d][c] == 0)) begin failures++; $display("[TB] FAIL rnd_empty k=%0d dut%0d ch%0d: got %b expected %b", k, d, c, e[c], (m_lvl[d][c] == 0)); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        mode = 1'b1;
        load = 4'b1111;
        for (int c = 0; c < CH; c++) init[c*LW +: LW] = LW'($urandom_range(1, IS));
        cycle();
        idle();
        inc = 4'b1111;
        #2;
        rst = 1'b0;
        model_reset();
        #2;
        checks += 4;
        if (out0 !== '0) begin failures++; $display("[TB] FAIL midrst_out0: got %h expected 0", out0); end
        if (outl !== '0) begin failures++; $display("[TB] FAIL midrst_outl: got %h expected 0", outl); end
        if (level0 !== '0) begin failures++; $display("[TB] FAIL midrst_level: got %h expected 0", level0); end
        if (empty0 !== 4'b1111) begin failures++; $display("[TB] FAIL midrst_empty: got %b expected 1111", empty0); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        inc = 4'b0001;
        cycle();
        checks += 3;
        if (level0[0 +: LW] !== 5'd1) begin failures++; $display("[TB] FAIL midrst_restart: got %0d expected 1", level0[0 +: LW]); end
        if (levell[0 +: LW] !== 5'd1) begin failures++; $display("[TB] FAIL midrst_restart_l: got %0d expected 1", levell[0 +: LW]); end
        if (level0[LW +: LW] !== 5'd0) begin failures++; $display("[TB] FAIL midrst_other: got %0d expected 0", level0[LW +: LW]); end
    endtask

    initial begin
        rst  = 1'b0;
        mode = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_saturation();
        test_simultaneous();
        test_leak();
        test_enable();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
